// File: rtl/heap_sort_pkg.sv
// Shared definitions for the heap sort engine: default sizes, FSM encoding and the
// layout of the packed state record {st, sz, idx, heap}.
package heap_sort_pkg;

    localparam int HS_KEY_W = 16;
    localparam int HS_DEPTH = 10;
    localparam int HS_IDX_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SIFT_UP   = 3'd1,
        SIFT_DOWN = 3'd2
    } hs_state_e;

    typedef struct packed {
        hs_state_e                            st;
        logic [HS_IDX_W-1:0]                  sz;
        logic [HS_IDX_W-1:0]                  idx;
        logic [HS_DEPTH-1:0][HS_KEY_W-1:0]    heap;
    } hs_rec_t;

endpackage

// File: rtl/heap_sift_down_select.sv
// One sift-down decision: picks the smallest of node idx and its in-range children.
// Ties between children resolve to the left child; only strict less-than moves away from idx.
module heap_sift_down_select
    import heap_sort_pkg::*;
#(
    parameter int KEY_W = HS_KEY_W,
    parameter int DEPTH = HS_DEPTH,
    parameter int IDX_W = HS_IDX_W
) (
    input  logic [DEPTH-1:0][KEY_W-1:0] heap,
    input  logic [IDX_W-1:0]            idx,
    input  logic [IDX_W-1:0]            count,
    output logic [IDX_W-1:0]            pick
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IDX_W-1:0] l_idx;
    logic [IDX_W-1:0] r_idx;
    logic [KEY_W-1:0] best;

    assign l_idx = IDX_W'({idx, 1'b1});
    assign r_idx = l_idx + IDX_W'(1);

    always_comb begin
        pick = idx;
        best = heap[AW'(idx)];
        if (l_idx < count && heap[AW'(l_idx)] < best) begin
            pick = l_idx;
            best = heap[AW'(l_idx)];
        end
        if (r_idx < count && heap[AW'(r_idx)] < best) begin
            pick = r_idx;
        end
    end

endmodule

// File: rtl/heap_sort_engine.sv
// Min-heap sort engine: push keys while drain=0, pop ascending keys while drain=1.
// Optional HEAP_SORT_PEAK_EN adds peak_count, the largest count seen since reset.
module heap_sort_engine
    import heap_sort_pkg::*;
#(
    parameter int KEY_W = HS_KEY_W,
    parameter int DEPTH = HS_DEPTH,
    parameter int IDX_W = HS_IDX_W
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [KEY_W-1:0] in_key,
    input  logic             drain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KEY_W-1:0] out_key,
    output logic [IDX_W-1:0] count,
    output logic             busy
`ifdef HEAP_SORT_PEAK_EN
    ,
    output logic [IDX_W-1:0] peak_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        hs_state_e                      st;
        logic [IDX_W-1:0]               sz;
        logic [IDX_W-1:0]               idx;
        logic [DEPTH-1:0][KEY_W-1:0]    heap;
    } rec_t;

    rec_t             rec_q, rec_d;
    logic             out_valid_q, out_valid_d;
    logic [KEY_W-1:0] out_key_q, out_key_d;
    logic [IDX_W-1:0] parent;
    logic [IDX_W-1:0] pick;
    logic             idle;
    logic             push_fire;
    logic             pop_fire;

    heap_sift_down_select #(
        .KEY_W (KEY_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_select (
        .heap  (rec_q.heap),
        .idx   (rec_q.idx),
        .count (rec_q.sz),
        .pick  (pick)
    );

    assign idle      = (rec_q.st == IDLE);
    assign parent    = (rec_q.idx - IDX_W'(1)) >> 1;
    assign in_ready  = idle & ~drain & (rec_q.sz < IDX_W'(DEPTH)) & ~system1000_rst;
    assign push_fire = in_ready & in_valid;
    assign pop_fire  = idle & drain & (rec_q.sz != '0) & (~out_valid_q | out_ready);

    always_comb begin
        rec_d       = rec_q;
        out_valid_d = out_valid_q;
        out_key_d   = out_key_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (rec_q.st)
            IDLE: begin
                if (push_fire) begin
                    rec_d.heap[AW'(rec_q.sz)] = in_key;
                    rec_d.idx                 = rec_q.sz;
                    rec_d.sz                  = rec_q.sz + IDX_W'(1);
                    rec_d.st                  = SIFT_UP;
                end else if (pop_fire) begin
                    out_key_d     = rec_q.heap[0];
                    out_valid_d   = 1'b1;
                    rec_d.heap[0] = rec_q.heap[AW'(rec_q.sz - IDX_W'(1))];
                    rec_d.sz      = rec_q.sz - IDX_W'(1);
                    rec_d.idx     = '0;
                    rec_d.st      = SIFT_DOWN;
                end
            end
            SIFT_UP: begin
                // The root never has a parent; test it first so no bogus index is compared.
                if (rec_q.idx == '0) begin
                    rec_d.st = IDLE;
                end else if (rec_q.heap[AW'(rec_q.idx)] >= rec_q.heap[AW'(parent)]) begin
                    rec_d.st = IDLE;
                end else begin
                    rec_d.heap[AW'(parent)]    = rec_q.heap[AW'(rec_q.idx)];
                    rec_d.heap[AW'(rec_q.idx)] = rec_q.heap[AW'(parent)];
                    rec_d.idx                  = parent;
                end
            end
            SIFT_DOWN: begin
                if (pick == rec_q.idx) begin
                    rec_d.st = IDLE;
                end else begin
                    rec_d.heap[AW'(pick)]      = rec_q.heap[AW'(rec_q.idx)];
                    rec_d.heap[AW'(rec_q.idx)] = rec_q.heap[AW'(pick)];
                    rec_d.idx                  = pick;
                end
            end
            default: begin
                rec_d.st = IDLE;
            end
        endcase
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            rec_q       <= '0;
            out_valid_q <= 1'b0;
            out_key_q   <= '0;
        end else begin
            rec_q       <= rec_d;
            out_valid_q <= out_valid_d;
            out_key_q   <= out_key_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_key   = out_key_q;
    assign count     = rec_q.sz;
    assign busy      = ~idle;

`ifdef HEAP_SORT_PEAK_EN
    logic [IDX_W-1:0] peak_q, peak_d;

    // Follows count one cycle late, so it settles the cycle after an increase.
    always_comb begin
        peak_d = (rec_q.sz > peak_q) ? rec_q.sz : peak_q;
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_count = peak_q;
`endif

endmodule

// File: tb/tb_heap_sort_engine.sv
// Self-checking bench for heap_sort_engine against a queue-based min-extraction model.
// Define HEAP_SORT_PEAK_EN for both files to exercise peak_count.
module tb_heap_sort_engine;

    localparam int KW = 16;
    localparam int IW = 16;

    logic          system1000;
    logic          system1000_rst;
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] in_key;
    logic          drain;
    logic          out_valid;
    logic          out_ready;
    logic [KW-1:0] out_key;
    logic [IW-1:0] count;
    logic          busy;
`ifdef HEAP_SORT_PEAK_EN
    logic [IW-1:0] peak_count;
`endif

    int checks = 0;
    int errors = 0;
    int mdl[$];
    int got[$];
    bit rand_rdy = 0;

    heap_sort_engine dut (
        .system1000     (system1000),
        .system1000_rst (system1000_rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_key         (in_key),
        .drain          (drain),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_key        (out_key),
        .count          (count),
        .busy           (busy)
`ifdef HEAP_SORT_PEAK_EN
        ,
        .peak_count     (peak_count)
`endif
    );

    initial system1000 = 1'b0;
    always #5 system1000 = ~system1000;

    // Consumer side: a key is taken on every edge where valid and ready are both high.
    always @(negedge system1000) begin
        if (!system1000_rst && out_valid && out_ready) got.push_back(int'(out_key));
    end

    always @(posedge system1000) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pop_min();
        int bi = 0;
        for (int i = 1; i < mdl.size(); i++) if (mdl[i] < mdl[bi]) bi = i;
        pop_min = mdl[bi];
        mdl.delete(bi);
    endfunction

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            @(negedge system1000);
            n++;
        end
        check(tag, int'(n <= 4), 1);
    endtask

    task automatic push(input logic [KW-1:0] k);
        int n = 0;
        @(negedge system1000);
        in_key   = k;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge system1000);
            n++;
        end
        check("push_ready", int'(in_ready), 1);
        if (in_ready) mdl.push_back(int'(k));
        @(negedge system1000);
        in_valid = 1'b0;
        wait_idle("push_latency");
        check("push_count", int'(count), mdl.size());
    endtask

    task automatic drain_all(input bit rnd);
        int exp_q[$];
        int n;
        int cyc = 0;
        while (mdl.size() > 0) exp_q.push_back(pop_min());
        n = exp_q.size();
        got.delete();
        @(posedge system1000);
        #2;
        out_ready = 1'b1;
        rand_rdy  = rnd;
        drain     = 1'b1;
        while (got.size() < n && cyc < 400) begin
            @(posedge system1000);
            #2;
            cyc++;
        end
        drain     = 1'b0;
        rand_rdy  = 0;
        out_ready = 1'b1;
        check("drain_len", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) check("drain_key", got[i], exp_q[i]);
        @(negedge system1000);
        wait_idle("drain_latency");
        check("drain_count", int'(count), 0);
    endtask

    task automatic do_reset();
        @(negedge system1000);
        system1000_rst = 1'b1;
        repeat (3) @(negedge system1000);
        system1000_rst = 1'b0;
        mdl.delete();
        got.delete();
    endtask

    initial begin
        system1000_rst = 1'b1;
        in_valid       = 1'b0;
        in_key         = '0;
        drain          = 1'b0;
        out_ready      = 1'b1;
        repeat (3) @(negedge system1000);
        check("rst_count", int'(count), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_key", int'(out_key), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        system1000_rst = 1'b0;

        // Basic ordering
        push(16'd5); push(16'd3); push(16'd8); push(16'd1);
        drain_all(0);

        // Full heap, overflow push ignored
        for (int k = 9; k >= 0; k--) push(16'(k));
        check("full_count", int'(count), 10);
        check("full_in_ready", int'(in_ready), 0);
        in_key   = 16'd77;
        in_valid = 1'b1;
        repeat (3) @(negedge system1000);
        check("full_ignored", int'(count), 10);
        in_valid = 1'b0;
        drain_all(0);

        // Duplicates
        push(16'd4); push(16'd4); push(16'd2); push(16'd4);
        drain_all(0);

        // Stalled consumer: one pop only, key held
        push(16'd7); push(16'd2); push(16'd9);
        @(posedge system1000);
        #2;
        out_ready = 1'b0;
        drain     = 1'b1;
        repeat (8) @(negedge system1000);
        check("stall_valid", int'(out_valid), 1);
        check("stall_key", int'(out_key), 2);
        check("stall_count", int'(count), 2);
        repeat (3) @(negedge system1000);
        check("stall_key_hold", int'(out_key), 2);
        check("stall_count_hold", int'(count), 2);
        drain_all(0);

        // Reset in the middle of a sift-down
        for (int i = 0; i < 6; i++) push(16'($urandom_range(0, 1000)));
        @(negedge system1000);
        drain = 1'b1;
        @(negedge system1000);
        check("mid_busy", int'(busy), 1);
        system1000_rst = 1'b1;
        @(posedge system1000);
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_busy", int'(busy), 0);
        @(negedge system1000);
        system1000_rst = 1'b0;
        drain = 1'b0;
        mdl.delete();
        got.delete();

        // Randomized rounds, alternating narrow (duplicate-heavy) and wide key ranges
        for (int r = 0; r < 8; r++) begin
            int n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++)
                push(16'((r % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 65535)));
            drain_all(r >= 4);
        end

`ifdef HEAP_SORT_PEAK_EN
        do_reset();
        check("peak_rst", int'(peak_count), 0);
        for (int i = 0; i < 7; i++) push(16'($urandom_range(0, 500)));
        begin
            int cyc = 0;
            got.delete();
            @(posedge system1000);
            #2;
            drain = 1'b1;
            while (got.size() < 3 && cyc < 100) begin
                @(posedge system1000);
                #2;
                cyc++;
            end
            drain = 1'b0;
            check("peak_pops", got.size(), 3);
            for (int i = 0; i < 3; i++) void'(pop_min());
            @(negedge system1000);
            wait_idle("peak_idle");
        end
        push(16'd11); push(16'd12);
        check("peak_count", int'(peak_count), 7);
        drain_all(0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
